// File: rtl/cd_toggle_monitor.sv
// cd_toggle_monitor: receive-side health monitor for a CDC toggle stream.
// Detects toggles on din and measures the Bclk interval between them.
// Declares lock after LOCK_EDGES consecutive in-range intervals and counts
// interval errors seen while locked. Enters a sticky FAULT at ERR_LIMIT errors.
module cd_toggle_monitor #(
  parameter int CNT_W      = 16,
  parameter int MIN_GAP    = 2,
  parameter int MAX_GAP    = 64,
  parameter int LOCK_EDGES = 4,
  parameter int ERR_LIMIT  = 3
) (
  input  logic             Bclk,
  input  logic             reset,
  input  logic             din,
  input  logic             clear,
  output logic             edge_pulse,
  output logic             locked,
  output logic             error,
  output logic [CNT_W-1:0] gap_last,
  output logic [CNT_W-1:0] edge_count,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    TRAIN  = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_e;

  localparam int               GOOD_W    = $clog2(LOCK_EDGES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] MIN_G     = CNT_W'(MIN_GAP);
  localparam logic [CNT_W-1:0] MAX_G     = CNT_W'(MAX_GAP);
  localparam logic [GOOD_W-1:0] LOCK_LAST = GOOD_W'(LOCK_EDGES - 1);
  localparam logic [7:0]       ERR_LIM   = 8'(ERR_LIMIT);

  state_e             state_q, state_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic               din_d_q, din_d_d;
  logic               primed_q, primed_d;
  logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]   gap_last_q, gap_last_d;
  logic [CNT_W-1:0]   edge_count_q, edge_count_d;
  logic [7:0]         err_count_q, err_count_d;
  logic               edge_pulse_q, edge_pulse_d;
  logic               locked_q, locked_d;
  logic               error_q, error_d;

  logic               edge_det;
  logic [CNT_W-1:0]   gap_next;
  logic               good_gap;
  logic               timeout;
  logic [7:0]         err_inc;

  // Next-state computation: edge detect, interval measurement, lock FSM, clear.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    good_d       = good_q;
    gap_last_d   = gap_last_q;
    edge_count_d = edge_count_q;
    err_count_d  = err_count_q;

    // The first clock after reset/clear only loads din_d; primed gates edges.
    edge_det = primed_q & (din ^ din_d_q);
    gap_next = (gap_cnt_q == CNT_MAX) ? CNT_MAX : gap_cnt_q + 1'b1;
    good_gap = (gap_next >= MIN_G) && (gap_next <= MAX_G);
    // gap_cnt keeps counting past MAX_G, so a silence times out only once.
    timeout  = !edge_det && ((state_q == TRAIN) || (state_q == LOCKED)) &&
               (gap_cnt_q == MAX_G);
    err_inc  = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;

    din_d_d      = din;
    primed_d     = 1'b1;
    edge_pulse_d = edge_det;
    gap_cnt_d    = edge_det ? '0 : gap_next;

    if (edge_det) begin
      gap_last_d   = gap_next;
      edge_count_d = (edge_count_q == CNT_MAX) ? CNT_MAX : edge_count_q + 1'b1;
    end

    unique case (state_q)
      SEEK: begin
        // The first edge after seeking carries no valid interval.
        if (edge_det) begin
          state_d = TRAIN;
          good_d  = '0;
        end
      end
      TRAIN: begin
        if (edge_det) begin
          if (good_gap) begin
            good_d = good_q + 1'b1;
            if (good_q == LOCK_LAST) state_d = LOCKED;
          end else begin
            good_d = '0;
          end
        end else if (timeout) begin
          state_d = SEEK;
        end
      end
      LOCKED: begin
        if ((edge_det && !good_gap) || timeout) begin
          err_count_d = err_inc;
          good_d      = '0;
          state_d     = (err_inc >= ERR_LIM) ? FAULT : TRAIN;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: state_d = SEEK;
    endcase

    // Soft clear wins over any coincident edge.
    if (clear) begin
      state_d      = SEEK;
      good_d       = '0;
      primed_d     = 1'b0;
      gap_cnt_d    = '0;
      gap_last_d   = '0;
      edge_count_d = '0;
      err_count_d  = '0;
      edge_pulse_d = 1'b0;
    end

    locked_d = (state_d == LOCKED);
    error_d  = (state_d == FAULT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Bclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= SEEK;
      good_q       <= '0;
      din_d_q      <= 1'b0;
      primed_q     <= 1'b0;
      gap_cnt_q    <= '0;
      gap_last_q   <= '0;
      edge_count_q <= '0;
      err_count_q  <= '0;
      edge_pulse_q <= 1'b0;
      locked_q     <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      good_q       <= good_d;
      din_d_q      <= din_d_d;
      primed_q     <= primed_d;
      gap_cnt_q    <= gap_cnt_d;
      gap_last_q   <= gap_last_d;
      edge_count_q <= edge_count_d;
      err_count_q  <= err_count_d;
      edge_pulse_q <= edge_pulse_d;
      locked_q     <= locked_d;
      error_q      <= error_d;
    end
  end

  assign edge_pulse = edge_pulse_q;
  assign locked     = locked_q;
  assign error      = error_q;
  assign gap_last   = gap_last_q;
  assign edge_count = edge_count_q;
  assign err_count  = err_count_q;

endmodule
